// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one ALU with registered-operand/late-opcode issue
module alu_arbiter #(
    parameter int WIDTH      = 32,
    parameter int OPW        = 4,
    parameter int FIXED_PRIO = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_y
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic          inflight0;
    logic          inflight1;
    logic          rr_prefer1;
    logic [SW-1:0] starve_cnt;
    logic          elig0;
    logic          elig1;
    logic          grant0;
    logic          grant1;
    logic          starve_force;

    // A requester may only be granted once its response slot will be free at capture time.
    assign elig0 = req0_valid && !inflight0 && (!rsp0_valid || rsp0_ready);
    assign elig1 = req1_valid && !inflight1 && (!rsp1_valid || rsp1_ready);
    assign starve_force = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if (FIXED_PRIO != 0) begin
                if (starve_force) grant1 = 1'b1;
                else              grant0 = 1'b1;
            end else begin
                if (rr_prefer1) grant1 = 1'b1;
                else            grant0 = 1'b1;
            end
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign alu_a = grant0 ? req0_a : (grant1 ? req1_a : '0);
    assign alu_b = grant0 ? req0_b : (grant1 ? req1_b : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_opcode <= '0;
            inflight0  <= 1'b0;
            inflight1  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_y     <= '0;
            rsp1_y     <= '0;
            rr_prefer1 <= 1'b0;
            starve_cnt <= '0;
        end else begin
            alu_opcode <= grant0 ? req0_op : (grant1 ? req1_op : '0);
            inflight0  <= grant0;
            inflight1  <= grant1;

            // The ALU result belongs to whichever requester issued last cycle.
            if (inflight0) begin
                rsp0_valid <= 1'b1;
                rsp0_y     <= alu_y;
            end else if (rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end

            if (inflight1) begin
                rsp1_valid <= 1'b1;
                rsp1_y     <= alu_y;
            end else if (rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end

            if (grant0 || grant1) rr_prefer1 <= grant0;

            if (FIXED_PRIO != 0) begin
                if (grant1)
                    starve_cnt <= '0;
                else if (elig1 && starve_cnt != STARVE_LIM)
                    starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized check of round-robin and fixed-priority arbiters against a transaction model
module tb_alu_arbiter;

    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_v0, in_v1, in_r0, in_r1;
    logic [31:0] in_a0, in_b0, in_a1, in_b1;
    logic [3:0]  in_op0, in_op1;

    logic [1:0]  o_rdy0, o_rdy1, o_rv0, o_rv1;
    logic [31:0] o_y0 [2];
    logic [31:0] o_y1 [2];
    logic [31:0] o_aa [2];
    logic [31:0] o_ab [2];
    logic [3:0]  o_op [2];
    logic [31:0] alu_y_w [2];
    logic [31:0] ax_q [2];
    logic [31:0] bx_q [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:    return a & b;
            4'd2:    return a | b;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return {31'b0, $signed(a) < $signed(b)};
            4'd6:    return a ^ b;
            4'd7:    return a << b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    alu_arbiter #(.WIDTH(32), .OPW(4), .FIXED_PRIO(0), .STARVE_MAX(SMAX)) u_rr (
        .clk(clk), .reset(reset),
        .req0_valid(in_v0), .req0_ready(o_rdy0[0]), .req0_a(in_a0), .req0_b(in_b0), .req0_op(in_op0),
        .req1_valid(in_v1), .req1_ready(o_rdy1[0]), .req1_a(in_a1), .req1_b(in_b1), .req1_op(in_op1),
        .rsp0_valid(o_rv0[0]), .rsp0_ready(in_r0), .rsp0_y(o_y0[0]),
        .rsp1_valid(o_rv1[0]), .rsp1_ready(in_r1), .rsp1_y(o_y1[0]),
        .alu_a(o_aa[0]), .alu_b(o_ab[0]), .alu_opcode(o_op[0]), .alu_y(alu_y_w[0])
    );

    alu_arbiter #(.WIDTH(32), .OPW(4), .FIXED_PRIO(1), .STARVE_MAX(SMAX)) u_fx (
        .clk(clk), .reset(reset),
        .req0_valid(in_v0), .req0_ready(o_rdy0[1]), .req0_a(in_a0), .req0_b(in_b0), .req0_op(in_op0),
        .req1_valid(in_v1), .req1_ready(o_rdy1[1]), .req1_a(in_a1), .req1_b(in_b1), .req1_op(in_op1),
        .rsp0_valid(o_rv0[1]), .rsp0_ready(in_r0), .rsp0_y(o_y0[1]),
        .rsp1_valid(o_rv1[1]), .rsp1_ready(in_r1), .rsp1_y(o_y1[1]),
        .alu_a(o_aa[1]), .alu_b(o_ab[1]), .alu_opcode(o_op[1]), .alu_y(alu_y_w[1])
    );

    // Behavioural ALU: operands registered, opcode applied combinationally.
    always @(posedge clk) begin
        ax_q[0] <= o_aa[0];
        bx_q[0] <= o_ab[0];
        ax_q[1] <= o_aa[1];
        bx_q[1] <= o_ab[1];
    end
    assign alu_y_w[0] = alu_f(o_op[0], ax_q[0], bx_q[0]);
    assign alu_y_w[1] = alu_f(o_op[1], ax_q[1], bx_q[1]);

    // Model: one outstanding transaction per requester, tracked by issue cycle.
    bit          has_txn [2][2];
    int          issue_cyc [2][2];
    logic [31:0] txn_res [2][2];
    logic [3:0]  txn_op [2][2];
    int          last_gnt [2];
    int          starve [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 2; n++) has_txn[m][n] = 1'b0;
            last_gnt[m] = 1;
            starve[m] = 0;
        end
    endtask

    task automatic model_step(input int m);
        bit inf [2];
        bit rv [2];
        bit el [2];
        bit g [2];
        bit vin [2];
        bit rin [2];
        logic [31:0] ea, eb;
        logic [3:0] eop;
        string nm;
        nm = (m == 0) ? "rr" : "fx";
        vin[0] = in_v0; vin[1] = in_v1;
        rin[0] = in_r0; rin[1] = in_r1;
        for (int n = 0; n < 2; n++) begin
            inf[n] = has_txn[m][n] && (issue_cyc[m][n] == cyc - 1);
            rv[n]  = has_txn[m][n] && (cyc >= issue_cyc[m][n] + 2);
            el[n]  = vin[n] && !inf[n] && (!rv[n] || rin[n]);
            g[n]   = 1'b0;
        end
        if (el[0] && el[1]) begin
            if (m == 1) begin
                if (starve[m] == SMAX) g[1] = 1'b1;
                else                   g[0] = 1'b1;
            end else begin
                if (last_gnt[m] == 0) g[1] = 1'b1;
                else                  g[0] = 1'b1;
            end
        end else begin
            g[0] = el[0];
            g[1] = el[1];
        end
        eop = inf[0] ? txn_op[m][0] : (inf[1] ? txn_op[m][1] : 4'd0);
        ea = g[0] ? in_a0 : (g[1] ? in_a1 : 32'd0);
        eb = g[0] ? in_b0 : (g[1] ? in_b1 : 32'd0);

        check_val({nm, ".ready0"}, 32'(o_rdy0[m]), 32'(g[0]));
        check_val({nm, ".ready1"}, 32'(o_rdy1[m]), 32'(g[1]));
        check_val({nm, ".rsp0_valid"}, 32'(o_rv0[m]), 32'(rv[0]));
        check_val({nm, ".rsp1_valid"}, 32'(o_rv1[m]), 32'(rv[1]));
        if (rv[0]) check_val({nm, ".rsp0_y"}, o_y0[m], txn_res[m][0]);
        if (rv[1]) check_val({nm, ".rsp1_y"}, o_y1[m], txn_res[m][1]);
        check_val({nm, ".alu_a"}, o_aa[m], ea);
        check_val({nm, ".alu_b"}, o_ab[m], eb);
        check_val({nm, ".alu_opcode"}, 32'(o_op[m]), 32'(eop));

        for (int n = 0; n < 2; n++)
            if (rv[n] && rin[n]) has_txn[m][n] = 1'b0;
        if (g[0]) begin
            has_txn[m][0] = 1'b1; issue_cyc[m][0] = cyc;
            txn_res[m][0] = alu_f(in_op0, in_a0, in_b0); txn_op[m][0] = in_op0;
            last_gnt[m] = 0;
        end
        if (g[1]) begin
            has_txn[m][1] = 1'b1; issue_cyc[m][1] = cyc;
            txn_res[m][1] = alu_f(in_op1, in_a1, in_b1); txn_op[m][1] = in_op1;
            last_gnt[m] = 1;
        end
        if (m == 1) begin
            if (g[1])                          starve[m] = 0;
            else if (el[1] && starve[m] < SMAX) starve[m]++;
        end
    endtask

    task automatic drive(input bit v0, input bit v1, input bit r0, input bit r1,
                         input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
        @(negedge clk);
        in_v0 = v0; in_v1 = v1; in_r0 = r0; in_r1 = r1;
        in_op0 = op0; in_a0 = a0; in_b0 = b0;
        in_op1 = op1; in_a1 = a1; in_b1 = b1;
        #1;
        if (reset) model_clear();
        else begin
            model_step(0);
            model_step(1);
        end
        cyc++;
    endtask

    function automatic logic [31:0] rnd_operand();
        return ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom;
    endfunction

    task automatic drive_rand(input bit v0, input bit v1, input bit r0, input bit r1);
        drive(v0, v1, r0, r1, 4'($urandom_range(1, 7)), rnd_operand(), rnd_operand(),
              4'($urandom_range(1, 7)), rnd_operand(), rnd_operand());
    endtask

    initial begin
        reset = 1'b1;
        in_v0 = 0; in_v1 = 0; in_r0 = 1; in_r1 = 1;
        in_a0 = 0; in_b0 = 0; in_a1 = 0; in_b1 = 0; in_op0 = 0; in_op1 = 0;
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Reset values, then a single ADD 5+7 through req0.
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            check_val("rst.rsp0_y", o_y0[m], 32'd0);
            check_val("rst.rsp1_y", o_y1[m], 32'd0);
        end
        drive(1, 0, 1, 1, 4'd3, 32'd5, 32'd7, 0, 0, 0);
        check_val("add.ready0", 32'(o_rdy0[0]), 32'd1);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        check_val("add.opcode", 32'(o_op[0]), 32'd3);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        check_val("add.rsp0_valid", 32'(o_rv0[0]), 32'd1);
        check_val("add.rsp0_y", o_y0[0], 32'd12);

        // SUB on req0 then SLT on req1, back to back.
        drive(1, 0, 1, 1, 4'd4, 32'd2, 32'd5, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0, 4'd5, 32'hFFFF_FFFF, 32'd0);
        check_val("sub.opcode", 32'(o_op[1]), 32'd4);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        check_val("slt.opcode", 32'(o_op[1]), 32'd5);
        check_val("sub.rsp0_y", o_y0[1], 32'hFFFF_FFFD);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        check_val("slt.rsp1_y", o_y1[1], 32'd1);

        // Both requesters saturating with responses always taken.
        for (int i = 0; i < 24; i++) drive_rand(1, 1, 1, 1);

        // Starvation: req1 only asks on every other cycle, when req0 also wins.
        for (int i = 0; i < 40; i++) drive_rand(1, (i % 2) == 0, 1, 1);

        // Response 0 held off, then released.
        for (int i = 0; i < 10; i++) drive_rand(1, 1, 0, 1);
        drive_rand(1, 1, 1, 1);
        for (int i = 0; i < 6; i++) drive_rand(1, 1, 1, 1);

        // Reset one cycle after an issue drops the op.
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 4'd3, 32'd1, 32'd1, 4'd3, 32'd2, 32'd2);
        reset = 1'b1;
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
            for (int m = 0; m < 2; m++) begin
                check_val("mrst.rsp0_valid", 32'(o_rv0[m]), 32'd0);
                check_val("mrst.rsp1_valid", 32'(o_rv1[m]), 32'd0);
            end
        end

        // Fully random traffic.
        for (int i = 0; i < 500; i++)
            drive_rand($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
